// File: rtl/floating_point_divider_if.sv
// Request/response bundle for the single-precision divider: operands in, quotient and status out.
interface floating_point_divider_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Quotient;
    logic        busy;
    logic        done;

    modport master (output start, A, B, input Quotient, busy, done);
    modport slave  (input start, A, B, output Quotient, busy, done);
endinterface

// File: rtl/floating_point_divider.sv
// IEEE-754 single-precision divider: restoring shift-subtract, one quotient bit per cycle,
// fixed 28-cycle latency for every operand class, round-to-nearest-even, no denormals.
module floating_point_divider (
    input  logic                           clk,
    input  logic                           rst_n,
    floating_point_divider_if.slave        bus
);
    localparam int unsigned QW = 26;
    localparam int unsigned MW = 24;
    localparam int unsigned RW = MW + 1;
    localparam int unsigned EW = 10;
    localparam int unsigned FW = 23;
    localparam logic [4:0]  LAST_ITER = 5'd25;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_e;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

    state_e                state_q, state_d;
    special_e              spec_q, spec_d, spec_c;
    logic [4:0]            cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [MW-1:0]         mb_q, mb_d;
    logic [QW-1:0]         quo_q, quo_d;
    logic [FW-1:0]         frac_q, frac_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           quotient_q, quotient_d;

    // Operand classification; exponent 0 (zero or denormal) is treated as signed zero.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (bus.A[30:23] == 8'h00);
    assign b_zero = (bus.B[30:23] == 8'h00);
    assign a_inf  = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] == 23'd0);
    assign b_inf  = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] == 23'd0);
    assign a_nan  = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] != 23'd0);
    assign b_nan  = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] != 23'd0);

    always_comb begin
        spec_c = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_c = SP_NAN;
        else if (a_inf || b_zero)                                      spec_c = SP_INF;
        else if (a_zero || b_inf)                                      spec_c = SP_ZERO;
    end

    // One restoring step: the remainder never exceeds twice the divisor, so RW bits suffice.
    logic          rem_ge;
    logic [RW-1:0] rem_sub;
    assign rem_ge  = (rem_q >= RW'(mb_q));
    assign rem_sub = rem_ge ? (rem_q - RW'(mb_q)) : rem_q;

    // Normalise to 24 bits + guard; a leading zero means the quotient is in [0.5, 1).
    logic [MW-1:0]        mant_pre;
    logic                 guard, sticky, round_up, carry;
    logic signed [EW-1:0] exp_norm;
    assign mant_pre = quo_q[QW-1] ? quo_q[QW-1:2] : quo_q[QW-2:1];
    assign guard    = quo_q[QW-1] ? quo_q[1] : quo_q[0];
    assign sticky   = (rem_q != '0) || (quo_q[QW-1] && quo_q[0]);
    assign round_up = guard && (sticky || mant_pre[0]);
    assign carry    = (&mant_pre) && round_up;
    assign exp_norm = quo_q[QW-1] ? exp_q : (exp_q - 10'sd1);

    logic [31:0] pack;
    always_comb begin
        pack = {sign_q, exp_q[7:0], frac_q};
        case (spec_q)
            SP_NAN:  pack = 32'h7FC0_0000;
            SP_INF:  pack = {sign_q, 8'hFF, 23'd0};
            SP_ZERO: pack = {sign_q, 31'd0};
            default: begin
                if (exp_q >= 10'sd255)     pack = {sign_q, 8'hFF, 23'd0};
                else if (exp_q <= 10'sd0)  pack = {sign_q, 31'd0};
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        spec_d     = spec_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        frac_d     = frac_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quotient_d = quotient_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DIVIDE;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    sign_d  = bus.A[31] ^ bus.B[31];
                    exp_d   = $signed(EW'({2'b00, bus.A[30:23]}) - EW'({2'b00, bus.B[30:23]}) + 10'd127);
                    rem_d   = {1'b0, 1'b1, bus.A[22:0]};
                    mb_d    = {1'b1, bus.B[22:0]};
                    quo_d   = '0;
                    spec_d  = spec_c;
                end
            end
            DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[QW-2:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ROUND;
                    cnt_d   = 5'd0;
                end
            end
            ROUND: begin
                // Two cycles: round into frac/exp first, then range-check and publish.
                if (cnt_q == 5'd0) begin
                    frac_d = mant_pre[FW-1:0] + FW'(round_up);
                    exp_d  = carry ? (exp_norm + 10'sd1) : exp_norm;
                    cnt_d  = 5'd1;
                end else begin
                    quotient_d = pack;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cnt_d      = 5'd0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            spec_q     <= SP_NONE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            frac_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quotient_q <= '0;
        end else begin
            state_q    <= state_d;
            spec_q     <= spec_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            frac_q     <= frac_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quotient_q <= quotient_d;
        end
    end

    assign bus.Quotient = quotient_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_floating_point_divider.sv
// Scoreboard bench for floating_point_divider: expected quotients queued at issue, checked on done.
module tb_floating_point_divider;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    floating_point_divider_if bus ();
    floating_point_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Acceptance as seen from the inputs: start while not busy and out of reset.
    always @(posedge clk) begin
        if (rst_n && bus.start && !bus.busy) acc_q.push_back(edge_n);
        edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                logic [31:0] want;
                int          acc;
                want = exp_q.pop_front();
                acc  = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                check_eq("quotient", bus.Quotient, want);
                check_eq("latency", 32'(edge_n - 1 - acc), 32'd28);
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
    endtask

    // Caller is at a negedge; returns at the negedge where done is visible.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        exp_q.push_back(q);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t vecs[15] = '{
        '{32'h40C00000, 32'h40000000, 32'h40400000},  // 6 / 2
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB},  // 1 / 3, rounds up
        '{32'hC0F00000, 32'h40200000, 32'hC0400000},  // -7.5 / 2.5
        '{32'h3F800000, 32'h00000000, 32'h7F800000},  // 1 / 0
        '{32'h00000000, 32'h40A80000, 32'h00000000},  // 0 / 5.25
        '{32'h00000000, 32'h00000000, 32'h7FC00000},  // 0 / 0
        '{32'h40000000, 32'h40400000, 32'h3F2AAAAB},  // 2 / 3
        '{32'h3F800000, 32'h3F800000, 32'h3F800000},  // 1 / 1
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000},  // NaN operand
        '{32'hFF800000, 32'h40000000, 32'hFF800000},  // -Inf / 2
        '{32'h40000000, 32'h7F800000, 32'h00000000},  // 2 / Inf
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000},  // Inf / -Inf
        '{32'h7F000000, 32'h00800000, 32'h7F800000},  // overflow
        '{32'h00800000, 32'h7F000000, 32'h00000000},  // underflow flush
        '{32'hBF800000, 32'h00000000, 32'hFF800000}   // -1 / 0
    };

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_quotient", bus.Quotient, 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each new request is driven in the done cycle.
        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q);

        repeat (5) @(negedge clk);
        check_eq("quotient_held", bus.Quotient, 32'hFF800000);

        // A second start mid-operation must be ignored.
        bus.A     = 32'h40C00000;
        bus.B     = 32'h40000000;
        bus.start = 1'b1;
        exp_q.push_back(32'h40400000);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("busy_mid", 32'(bus.busy), 32'd1);
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (35) @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation aborts with no done pulse.
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_quotient", bus.Quotient, 32'h0);
        acc_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/floating_point_divider.md
FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 The block SHALL have no parameters; the operand format SHALL be fixed IEEE-754 single precision, 32 bits, laid out as {sign, exp[7:0], mantissa[22:0]}.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; operands are sampled on any rising edge where start=1 and busy=0.
REQ-005 A  input  32  dividend, IEEE-754 single.
REQ-006 B  input  32  divisor, IEEE-754 single.
REQ-007 Quotient  output  32  A/B, IEEE-754 single; SHALL be registered and held until the next completion.
REQ-008 busy  output  1  high from the edge after acceptance until the edge on which done is raised.
REQ-009 done  output  1  one-cycle completion pulse; Quotient is valid in that cycle and afterwards.

Function
REQ-010 FSM states SHALL be IDLE, DIVIDE and ROUND; done SHALL be a registered output of the ROUND to IDLE transition.
REQ-011 On acceptance in IDLE, the block SHALL latch sign=A[31]^B[31], exp=A.exp-B.exp+127 (10-bit signed), and 24-bit mantissas with the hidden 1 restored, then enter DIVIDE.
REQ-012 DIVIDE SHALL run a restoring shift-subtract division at one quotient bit per cycle for exactly 26 cycles, tracked by a 5-bit iteration counter.
REQ-013 ROUND SHALL normalise as follows:
- If quotient bit 25 is 0, shift left by 1 and decrement exp.
- Take 24 result bits plus a guard bit.
- Sticky = (remainder != 0).
REQ-014 Rounding SHALL be round-to-nearest-even; a mantissa carry-out SHALL renormalise and increment exp.
REQ-015 Latency SHALL be fixed for every operand class: done=1 exactly 28 rising edges after the accepting edge.
REQ-016 start asserted while busy=1 SHALL be ignored; start held continuously SHALL start back-to-back operations, one per 29 cycles (1 IDLE cycle each).
REQ-017 Special cases SHALL be decided at acceptance and applied in ROUND; they still obey REQ-015.
REQ-018 Denormal inputs (exp=0) SHALL be treated as signed zero.
REQ-019 Special-case results SHALL be:
- NaN input, 0/0 or Inf/Inf: 0x7FC00000.
- x/0 with x finite nonzero: signed infinity.
- Inf/x with x finite: signed infinity.
- 0/x with x nonzero, or x/Inf with x finite: signed zero.
REQ-020 Post-round exp >= 255 SHALL produce signed infinity; exp <= 0 SHALL flush to signed zero (no denormal output).
REQ-021 The sign SHALL apply to zero and infinity results; a NaN result SHALL always carry sign=0.

Reset
REQ-022 While rst_n=0, the state SHALL be IDLE, Quotient=0x00000000, busy=0, done=0, and the counter and datapath registers SHALL be cleared, all asynchronously.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-024 The bench SHALL cover A=0x40C00000 (6.0), B=0x40000000 (2.0) -> Quotient=0x40400000, with done exactly 28 cycles after the start edge.
REQ-025 The bench SHALL cover A=0x3F800000 (1.0), B=0x40400000 (3.0) -> Quotient=0x3EAAAAAB (round-up path).
REQ-026 The bench SHALL cover A=0xC0F00000 (-7.5), B=0x40200000 (2.5) -> Quotient=0xC0400000.
REQ-027 The bench SHALL cover the special cases with these results:
- 0x3F800000/0x00000000 -> 0x7F800000.
- 0x00000000/0x40A80000 -> 0x00000000.
- 0x00000000/0x00000000 -> 0x7FC00000.
REQ-028 The bench SHALL pulse start again at cycle 10 of an active operation -> ignored, a single done, Quotient from the first operands.
REQ-029 The bench SHALL assert rst_n=0 at cycle 15 of an operation -> busy=0, done=0 and Quotient=0 immediately; a following 6.0/2.0 request SHALL complete correctly.
